// File: rtl/rca_chk_pkg.sv
// rca_chk_pkg: shared state encodings, vector width and vector bit-slice positions for adder checkers
package rca_chk_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SETTLE = 2'd1, ST_CHECK = 2'd2, ST_DONE = 2'd3;
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    CHECK  = ST_CHECK,
    DONE   = ST_DONE
  } state_t;
  localparam int A_LSB = 0;
  function automatic int vec_width(input int width);
    return 2 * width + 1;
  endfunction
  function automatic int b_lsb(input int width);
    return width;
  endfunction
  function automatic int cin_pos(input int width);
    return 2 * width;
  endfunction
endpackage

// File: rtl/rca_golden_adder.sv
// rca_golden_adder: behavioural reference add producing {carry_out, sum} at WIDTH+1 bits
module rca_golden_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   s
);
  assign s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/rca_fault_checker.sv
// rca_fault_checker: exhaustive {cin,b,a} sweep of an external adder with mismatch count and first-fail capture
// Define RCA_CHK_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module rca_fault_checker
  import rca_chk_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  localparam int VW           = vec_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [VW:0]      err_count,
  output logic             first_fail_valid,
  output logic [VW-1:0]    first_fail_vec
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int BL = b_lsb(WIDTH);
  localparam int CP = cin_pos(WIDTH);
  state_t state, state_nxt;
  logic [VW-1:0] vec;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] golden;
  logic mis, last, settled, stop, accept;
  assign dut_a   = vec[A_LSB +: WIDTH];
  assign dut_b   = vec[BL +: WIDTH];
  assign dut_cin = vec[CP];
  rca_golden_adder #(.WIDTH(WIDTH)) u_golden (
    .a  (dut_a),
    .b  (dut_b),
    .cin(dut_cin),
    .s  (golden)
  );
  assign mis     = {dut_cout, dut_sum} != golden;
  assign last    = &vec;
  assign settled = cnt == CW'(SETTLE_CYCLES - 1);
  assign accept  = (state == IDLE || state == DONE) && start;
  assign busy    = state == SETTLE || state == CHECK;
  assign done    = state == DONE;
  assign pass    = done && err_count == '0;
`ifdef RCA_CHK_STOP_ON_FAIL_EN
  assign stop = mis;
`else
  assign stop = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: state_nxt = start ? SETTLE : state;
      SETTLE:     state_nxt = settled ? CHECK : SETTLE;
      CHECK:      state_nxt = (last || stop) ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      vec              <= '0;
      cnt              <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == SETTLE && !settled) ? cnt + CW'(1) : '0;
      if (accept) begin
        vec              <= '0;
        err_count        <= '0;
        first_fail_valid <= 1'b0;
        first_fail_vec   <= '0;
      end
      if (state == CHECK) begin
        if (mis) begin
          err_count <= err_count + (VW+1)'(1);
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= vec;
          end
        end
        if (state_nxt == SETTLE) vec <= vec + VW'(1);
      end
    end
  end
endmodule

// File: tb/tb_rca_fault_checker.sv
// tb_rca_fault_checker: scoreboard bench driving ideal and fault-injected 4-bit adders into rca_fault_checker
module tb_rca_fault_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] dut_a, dut_b, dut_sum;
  logic dut_cin, dut_cout, busy, done, pass, first_fail_valid;
  logic [9:0] err_count;
  logic [8:0] first_fail_vec;
  int mode_r = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int cycles;
    int err;
    int ffv;
    int ffvalid;
    int pass;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  rca_fault_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .dut_a           (dut_a),
    .dut_b           (dut_b),
    .dut_cin         (dut_cin),
    .dut_sum         (dut_sum),
    .dut_cout        (dut_cout),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_fail_valid(first_fail_valid),
    .first_fail_vec  (first_fail_vec)
  );
  // Mode 0 ideal, 1 ripple adder with cout = c3 & c4, 2 sum[0] stuck-at-0.
  function automatic logic [4:0] adder_model(input int m, input logic [8:0] v);
    logic [4:0] s;
    logic [3:0] lo;
    s  = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
    lo = {1'b0, v[2:0]} + {1'b0, v[6:4]} + {3'b0, v[8]};
    if (m == 1) s[4] = s[4] & lo[3];
    if (m == 2) s[0] = 1'b0;
    return s;
  endfunction
  always_comb {dut_cout, dut_sum} = adder_model(mode_r, {dut_cin, dut_b, dut_a});
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic push_expected(input int m);
    exp_t e;
    e = '{cycles: 1024, err: 0, ffv: 0, ffvalid: 0, pass: 1};
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      if (int'(adder_model(m, vv)) != int'(vv[3:0]) + int'(vv[7:4]) + int'(vv[8])) begin
        if (e.ffvalid == 0) begin
          e.ffvalid = 1;
          e.ffv = v;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
`ifdef RCA_CHK_STOP_ON_FAIL_EN
    if (e.ffvalid != 0) begin
      e.err = 1;
      e.cycles = (e.ffv + 1) * 2;
    end
`endif
    sb.push_back(e);
  endtask
  task automatic run(input int m, input bit pulse_mid);
    exp_t e;
    int n;
    mode_r = m;
    push_expected(m);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_done", done, 0);
    check("accept_err", err_count, 0);
    check("accept_ffvalid", first_fail_valid, 0);
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1 n++;
      if (pulse_mid && n == 300) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n++;
      end
    end
    e = sb.pop_front();
    check("run_cycles", n, e.cycles);
    check("run_err", err_count, e.err);
    check("run_ffvalid", first_fail_valid, e.ffvalid);
    check("run_ffvec", first_fail_vec, e.ffv);
    check("run_pass", pass, e.pass);
    check("run_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 check("hold_done", done, 1);
    check("hold_err", err_count, e.err);
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_ffvalid", first_fail_valid, 0);
    check("rst_ffvec", first_fail_vec, 0);
    check("rst_vec", {dut_cin, dut_b, dut_a}, 0);
    run(0, 1'b1);
    run(1, 1'b0);
    run(2, 1'b0);
    mode_r = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while ({dut_cin, dut_b, dut_a} != 9'd100 && n < 1000) begin
      @(posedge clk); #1 n++;
    end
    check("mid_reached_vec", {dut_cin, dut_b, dut_a}, 100);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_ffvalid", first_fail_valid, 0);
    check("mid_rst_a", dut_a, 0);
    check("mid_rst_b", dut_b, 0);
    check("mid_rst_cin", dut_cin, 0);
    run(0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rca_fault_checker.md
Name: rca_fault_checker

Overview:
- Exhaustive self-test controller for the team's WIDTH-bit ripple-carry adder (structural NAND-based RCA).
- Drives every {cin, b, a} combination into the adder under test, waits for settling, and compares {cout, sum} against an internal golden sum.
- Counts mismatches and captures the first failing vector.
- Sits beside the adder as its stimulus source and response checker, for lab bring-up of fault-injected adders.

Parameters:
- WIDTH, 4, adder operand width; vector index VW = 2*WIDTH+1 bits.
- SETTLE_CYCLES, 1, clock cycles a vector is held before sampling; must be >=1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request, sampled in IDLE or DONE.
- dut_a  out  WIDTH  adder operand a.
- dut_b  out  WIDTH  adder operand b.
- dut_cin  out  1  adder carry-in.
- dut_sum  in  WIDTH  adder sum.
- dut_cout  in  1  adder carry-out.
- busy  out  1  high while a run is in progress.
- done  out  1  high from end of run until next accepted start or rst.
- pass  out  1  valid when done; 1 iff err_count==0.
- err_count  out  VW+1  number of mismatching vectors in the last run.
- first_fail_valid  out  1  a mismatch has been captured.
- first_fail_vec  out  VW  index {cin,b,a} of the first mismatch.

Behaviour:
- Reset (synchronous, active-high; the only reset path): state=IDLE; vec=0; busy=0; done=0; pass=0; err_count=0; first_fail_valid=0; first_fail_vec=0; dut_a/dut_b/dut_cin=0.
- dut_{cin,b,a} = vec register, bit-sliced as {cin, b[WIDTH-1:0], a[WIDTH-1:0]} with a in the LSBs. Outputs are driven from registers, so they are glitch-free.
- Golden model: {gc, gs} = a + b + cin, computed at WIDTH+1 bits.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1 -> SETTLE. On this transition clear vec, err_count, first_fail_*, done and pass.
- SETTLE: hold the vector for SETTLE_CYCLES cycles (internal counter), then go to CHECK.
- CHECK (one cycle): sample dut_sum/dut_cout. On mismatch: err_count+1; if !first_fail_valid, capture vec and set first_fail_valid.
  - If vec == 2^VW-1 -> DONE.
  - Else vec+1 -> SETTLE.
- The vector changes only on the CHECK->SETTLE edge.
- Per-vector cost is SETTLE_CYCLES+1 cycles. Total: start-accept cycle to done=1 is 2^VW*(SETTLE_CYCLES+1) cycles.
- DONE: done=1, busy=0, pass=(err_count==0). Results are held until the next start.
- busy=1 exactly in SETTLE/CHECK. start while busy is ignored.
- err_count cannot overflow: its width holds 2^VW.
- rst asserted mid-run: returns to IDLE on the next edge, discarding partial results.

Optional Feature:
- Macro RCA_CHK_STOP_ON_FAIL_EN.
  - Defined: the first mismatch in CHECK goes directly to DONE. err_count=1, first_fail_vec=failing index, pass=0.
  - Undefined: the full exhaustive sweep always runs.
  - A passing run behaves identically in both builds.

Decomposition:
- Shared package/include rca_chk_pkg holds:
  - state encodings (2-bit localparams);
  - VW derivation;
  - the vector bit-slice positions.
- One sub-module: rca_golden_adder (behavioural WIDTH-bit add producing {gc, gs}). It is reused by future adder/subtractor checkers.
- FSM, counters and capture logic stay in rca_fault_checker.

Test Plan:
- Bench connects an ideal behavioural adder, WIDTH=4, SETTLE_CYCLES=1, pulses start -> done after exactly 1024 cycles; pass=1, err_count=0, first_fail_valid=0.
- Connect the team's 4-bit RCA with the cout=c3&c4 fault -> err_count=64, first_fail_vec=9'h088 (a=8, b=8, cin=0), pass=0.
- Ideal adder with sum[0] forced stuck-at-0 -> err_count=256, first_fail_vec=9'h001.
- Assert rst for one cycle while vec=100 -> next cycle busy=0, err_count=0, done=0, dut_a/dut_b/dut_cin=0. A subsequent start completes normally in 1024 cycles.
- Pulse start mid-run -> no effect, run ends on schedule. Pulse start in DONE -> results cleared the next cycle and a new sweep begins.
- With RCA_CHK_STOP_ON_FAIL_EN and the cout fault -> done after 137*2=274 cycles, err_count=1, first_fail_vec=9'h088.
